// File: rtl/lsu_mem_master.sv
// lsu_mem_master: RV32I load/store initiator for a single-port word memory, with read-modify-write for sub-word stores.
module lsu_mem_master #(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP} state_t;
  state_t state, state_n;
  logic [2:0] f3_q;
  logic [IDX_W+1:0] addr_q;
  logic [31:0] wdata_q, word_q, lane, load_val, mask, merged;
  logic [4:0] sh;
  logic bad, mem_act;
  always_comb begin
    bad = (req_addr[31:IDX_W+2] != '0)
       || (req_we ? (req_funct3 > 3'd2) : (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110))
       || (req_funct3[1:0] == 2'b01 && req_addr[0])
       || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    state_n = state == IDLE ? (req_valid ? (bad ? RESP : req_we ? (req_funct3[1] ? WRITE : RMW_RD) : LOAD) : IDLE)
            : state == RMW_RD ? RMW_WR
            : state == RESP ? IDLE
            : RESP;
    sh = {addr_q[1:0], 3'b000};
    lane = mem_rd >> sh;
    load_val = f3_q == 3'b000 ? {{24{lane[7]}}, lane[7:0]}
             : f3_q == 3'b001 ? {{16{lane[15]}}, lane[15:0]}
             : f3_q == 3'b100 ? {24'b0, lane[7:0]}
             : f3_q == 3'b101 ? {16'b0, lane[15:0]}
             : mem_rd;
    // Sub-word store: replace only the addressed lane(s) of the word read back.
    mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    merged = (word_q & ~mask) | ((wdata_q << sh) & mask);
    mem_act = state == LOAD || state == WRITE || state == RMW_RD || state == RMW_WR;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    mem_we = (state == WRITE || state == RMW_WR) && !rst;
    mem_a = (mem_act && !rst) ? {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]} : 32'b0;
    mem_wd = !mem_we ? 32'b0 : state == WRITE ? wdata_q : merged;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      word_q <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        f3_q <= req_funct3;
        addr_q <= req_addr[IDX_W+1:0];
        wdata_q <= req_wdata;
        if (bad) begin
          resp_rdata <= '0;
          resp_err <= 1'b1;
        end
      end
      if (state == LOAD) begin
        resp_rdata <= load_val;
        resp_err <= 1'b0;
      end
      if (state == WRITE || state == RMW_WR) begin
        resp_rdata <= '0;
        resp_err <= 1'b0;
      end
      if (state == RMW_RD) word_q <= mem_rd;
    end
  end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator driving the single-port 32-bit data memory: word index on A, write data on WD, write enable WE, combinational read on RD.
- Accepts byte-addressed RV32I load/store requests from the execute/memory stage through a valid/ready handshake.
- Performs read-modify-write for sub-word stores.
- Returns one response per request, with sign/zero-extended load data and an error flag.

Parameters:
DEPTH, 32, number of 32-bit words in the attached data memory
IDX_W, 5, word-index width; equals clog2(DEPTH)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32I funct3: size/sign of access
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, out-of-range or illegal funct3
mem_we  output  1  memory write enable
mem_a  output  32  memory word index, zero-extended from IDX_W bits
mem_wd  output  32  memory write data
mem_rd  input  32  memory read data, combinational from mem_a

Behaviour:
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP.
- req_ready is 1 only in IDLE. A request is accepted on a clk edge when req_valid && req_ready.
- On accept, latch we, funct3, addr and wdata.
- Word index is addr[IDX_W+1:2]. Byte lane is addr[1:0], little-endian: lane 0 = bits 7:0.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
- Error cases (any one sets error and sends IDLE->RESP with no memory access):
  - any other funct3
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:IDX_W+2] != 0
- Normal transitions:
  - Load: IDLE->LOAD->RESP. In LOAD: mem_a = index; extract the lane from mem_rd, extend it, register into resp_rdata.
  - SW: IDLE->WRITE->RESP. In WRITE: mem_we=1, mem_wd=wdata.
  - SB/SH: IDLE->RMW_RD->RMW_WR->RESP.
    - RMW_RD registers mem_rd.
    - RMW_WR drives mem_we=1 and mem_wd = registered word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. Other bytes are unchanged.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_rdata and resp_err are valid in that cycle. Next state IDLE.
  - req_ready stays 0 in RESP, so there are no back-to-back accepts. The next accept is possible the cycle after RESP.
- Latency (accept edge to resp_valid high): load 2, SW 2, SB/SH 3, error 1 cycles.
- mem_we is high only in WRITE or RMW_WR, and is gated combinationally by !rst.
- mem_a holds the latched index in LOAD, WRITE, RMW_RD and RMW_WR; otherwise 0.
- mem_wd is 0 when mem_we=0.
- Response data rules:
  - resp_rdata and resp_err hold their last values outside RESP.
  - resp_rdata is cleared to 0 for store and error responses.
  - resp_err is 0 on success.
- Reset (sampled at clk edge):
  - state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latched fields=0.
  - mem_we=0 and mem_a=0 in any cycle with rst=1.
- Reset mid-operation abandons the request with no response. Asserting rst during the RMW_WR cycle suppresses the write, so memory is unchanged.
- req_valid is ignored while not in IDLE. The requester holds the request until ready; a request dropped before accept has no effect.

Test Plan:
- Memory preloaded mem[3]=0x80FF_7F01. LB addr 0x0D -> resp 2 cycles after accept, rdata=0x0000_007F. LB addr 0x0F -> 0xFFFF_FF80. LBU addr 0x0F -> 0x0000_0080. LH addr 0x0E -> 0xFFFF_80FF.
- SW addr 0x10, wdata 0xDEAD_BEEF -> mem_we high exactly one cycle with mem_a=4. resp_err=0, resp_rdata=0. A following LW 0x10 returns 0xDEAD_BEEF.
- mem[5]=0x1122_3344. SB addr 0x16, wdata 0xAB -> one read cycle, then write 0x11AB_3344. SH addr 0x14, wdata 0xCAFE -> 0x11AB_CAFE. Response 3 cycles after accept in both cases.
- LW addr 0x02, SH addr 0x01, funct3 011, and addr 0x80 (index 32) -> resp_err=1 one cycle after accept, mem_we never asserted, rdata=0.
- Back-to-back: req_valid held high for LW then SW. The second request is accepted only the cycle after the first RESP; req_ready is low in all intermediate cycles.
- Assert rst in the RMW_WR cycle of SB to mem[2]=0x0 -> mem_we stays 0, no resp_valid, mem[2] still 0, req_ready=1 the cycle after reset deasserts.
